// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game blocks: state encoding, screen
// geometry, LFSR seed/taps and the gap-height draw helper.
package flappy_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HIT  = 2'd2
   } state_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Right-shift Galois feedback mask for x^8+x^6+x^5+x^4+1 (maximal length).
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // Gap top = minimum Y plus seven random bits.
   function automatic logic [9:0] draw_gap(input logic [9:0] gap_min, input logic [6:0] rnd);
      return gap_min + {3'b000, rnd};
   endfunction

endpackage

// File: rtl/flappy_lfsr8.sv
// Free-running 8-bit Galois LFSR. A non-zero seed keeps it off the all-zero
// lock-up state forever.
module flappy_lfsr8
   import flappy_pkg::*;
#(
   parameter logic [7:0] SEED = LFSR_SEED
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] lfsr
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   // Next value: shift right, fold the tap mask in when a one falls out.
   always_comb begin
      lfsr_d = {1'b0, lfsr_q[7:1]};
      if (lfsr_q[0]) begin
         lfsr_d = lfsr_d ^ LFSR_TAPS;
      end
   end

   // State register, reloads the seed on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/pipe_collision.sv
// Pipe scroller, scorekeeper and collision detector. Consumes the bird box
// from flight_physics, drives pipe geometry to the renderer and raises
// Collision until the game controller acknowledges it.
module pipe_collision #(
   parameter int SCREEN_W     = flappy_pkg::SCREEN_W,
   parameter int SCREEN_H     = flappy_pkg::SCREEN_H,
   parameter int PIPE_W       = 60,
   parameter int GAP_H        = 120,
   parameter int GAP_MIN      = 80,
   parameter int PIPE_SPACING = 320,
   parameter int SCROLL_DIV   = 200000
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic       Start,
   input  logic       Ack,
   input  logic [9:0] Bird_X_L,
   input  logic [9:0] Bird_X_R,
   input  logic [9:0] Bird_Y_T,
   input  logic [9:0] Bird_Y_B,
   output logic [9:0] Pipe0_XR,
   output logic [9:0] Pipe1_XR,
   output logic [9:0] Pipe0_GapT,
   output logic [9:0] Pipe1_GapT,
   output logic [7:0] Score,
   output logic       Collision,
   output logic       q_Idle,
   output logic       q_Run,
   output logic       q_Hit
);
   import flappy_pkg::*;

   localparam int               CNT_W      = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCROLL_DIV - 1);
   localparam logic [9:0]       XR0_RST    = 10'(SCREEN_W + PIPE_W);
   localparam logic [9:0]       XR1_RST    = 10'(SCREEN_W + PIPE_W + PIPE_SPACING);
   localparam logic [9:0]       GAP_MIN_V  = 10'(GAP_MIN);
   localparam logic [9:0]       SPACING_V  = 10'(PIPE_SPACING);
   localparam logic [10:0]      PIPE_W_11  = 11'(PIPE_W);
   localparam logic [10:0]      GAP_H_11   = 11'(GAP_H);
   localparam logic [10:0]      FLOOR_Y_11 = 11'(SCREEN_H - 1);

   // Geometry must fit the 10-bit coordinate registers.
   if (SCREEN_W + PIPE_W + PIPE_SPACING > 1023) begin : g_bad_geometry
      $error("pipe_collision: SCREEN_W+PIPE_W+PIPE_SPACING exceeds 1023");
   end
   if (SCROLL_DIV < 1) begin : g_bad_scroll_div
      $error("pipe_collision: SCROLL_DIV must be at least 1");
   end

   state_t           state_q, state_d;
   logic [9:0]       xr0_q, xr0_d;
   logic [9:0]       xr1_q, xr1_d;
   logic [9:0]       gap0_q, gap0_d;
   logic [9:0]       gap1_q, gap1_d;
   logic [7:0]       score_q, score_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       lfsr;
   logic             tick;
   logic             hit;

   flappy_lfsr8 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (Clk),
      .rst_n (reset),
      .lfsr  (lfsr)
   );

   // Pipe-vs-bird test in 11 bits so neither the clamped left edge nor the
   // gap bottom can wrap.
   function automatic logic pipe_hit(input logic [9:0] xr, input logic [9:0] gap_t,
                                     input logic [9:0] bx_l, input logic [9:0] bx_r,
                                     input logic [9:0] by_t, input logic [9:0] by_b);
      logic [10:0] left;
      logic [10:0] gap_b;
      logic        horiz;
      logic        vert;
      left  = ({1'b0, xr} < PIPE_W_11) ? 11'd0 : ({1'b0, xr} - PIPE_W_11);
      gap_b = {1'b0, gap_t} + GAP_H_11;
      horiz = ({1'b0, bx_r} >= left) && (bx_l < xr);
      vert  = (by_t < gap_t) || ({1'b0, by_b} > gap_b);
      return horiz && vert;
   endfunction

   // Scroll tick and collision condition from current inputs and pipe state.
   always_comb begin
      tick = (cnt_q == CNT_LAST);
      hit  = ({1'b0, Bird_Y_B} >= FLOOR_Y_11)
          || (Bird_Y_T == 10'd0)
          || pipe_hit(xr0_q, gap0_q, Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B)
          || pipe_hit(xr1_q, gap1_q, Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B);
   end

   // Game FSM and pipe/score datapath next-state; a hit suppresses any
   // concurrent scroll so the frozen frame is the one that collided.
   always_comb begin
      state_d = state_q;
      xr0_d   = xr0_q;
      xr1_d   = xr1_q;
      gap0_d  = gap0_q;
      gap1_d  = gap1_q;
      score_d = score_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            xr0_d = XR0_RST;
            xr1_d = XR1_RST;
            if (Start) begin
               state_d = ST_RUN;
               score_d = 8'd0;
               gap0_d  = draw_gap(GAP_MIN_V, lfsr[6:0]);
               gap1_d  = draw_gap(GAP_MIN_V, lfsr[7:1]);
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            if (hit) begin
               state_d = ST_HIT;
            end else if (tick) begin
               cnt_d = '0;
               if (xr0_q == 10'd0) begin
                  xr1_d  = xr1_q - 10'd1;
                  xr0_d  = xr1_q - 10'd1 + SPACING_V;
                  gap0_d = draw_gap(GAP_MIN_V, lfsr[6:0]);
               end else if (xr1_q == 10'd0) begin
                  xr0_d  = xr0_q - 10'd1;
                  xr1_d  = xr0_q - 10'd1 + SPACING_V;
                  gap1_d = draw_gap(GAP_MIN_V, lfsr[6:0]);
               end else begin
                  xr0_d = xr0_q - 10'd1;
                  xr1_d = xr1_q - 10'd1;
               end
               if (((xr0_q == Bird_X_L) || (xr1_q == Bird_X_L)) && (score_q != 8'hFF)) begin
                  score_d = score_q + 8'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HIT: begin
            if (Ack) begin
               state_d = ST_IDLE;
               xr0_d   = XR0_RST;
               xr1_d   = XR1_RST;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // All game state registers share the asynchronous reset.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         xr0_q   <= XR0_RST;
         xr1_q   <= XR1_RST;
         gap0_q  <= GAP_MIN_V;
         gap1_q  <= GAP_MIN_V;
         score_q <= 8'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         xr0_q   <= xr0_d;
         xr1_q   <= xr1_d;
         gap0_q  <= gap0_d;
         gap1_q  <= gap1_d;
         score_q <= score_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Pipe0_XR   = xr0_q;
   assign Pipe1_XR   = xr1_q;
   assign Pipe0_GapT = gap0_q;
   assign Pipe1_GapT = gap1_q;
   assign Score      = score_q;
   assign Collision  = (state_q == ST_HIT);
   assign q_Idle     = (state_q == ST_IDLE);
   assign q_Run      = (state_q == ST_RUN);
   assign q_Hit      = (state_q == ST_HIT);

endmodule

// File: tb/tb_pipe_collision.sv
// Directed bench for pipe_collision with a one-clock scroll step.
module tb_pipe_collision;

   logic       Clk = 1'b0;
   logic       reset;
   logic       Start;
   logic       Ack;
   logic [9:0] Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B;
   logic [9:0] Pipe0_XR, Pipe1_XR, Pipe0_GapT, Pipe1_GapT;
   logic [7:0] Score;
   logic       Collision, q_Idle, q_Run, q_Hit;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference LFSR: x^8+x^6+x^5+x^4+1, Galois right shift, seed A5.
   logic [7:0] m_lfsr;

   pipe_collision #(
      .SCROLL_DIV (1)
   ) dut (
      .Clk        (Clk),
      .reset      (reset),
      .Start      (Start),
      .Ack        (Ack),
      .Bird_X_L   (Bird_X_L),
      .Bird_X_R   (Bird_X_R),
      .Bird_Y_T   (Bird_Y_T),
      .Bird_Y_B   (Bird_Y_B),
      .Pipe0_XR   (Pipe0_XR),
      .Pipe1_XR   (Pipe1_XR),
      .Pipe0_GapT (Pipe0_GapT),
      .Pipe1_GapT (Pipe1_GapT),
      .Score      (Score),
      .Collision  (Collision),
      .q_Idle     (q_Idle),
      .q_Run      (q_Run),
      .q_Hit      (q_Hit)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk or negedge reset) begin
      if (!reset) m_lfsr <= 8'hA5;
      else        m_lfsr <= {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   int         mxr0, mxr1, mg0, mg1, ms, g;
   bit         scored, resp;
   logic [7:0] L;

   initial begin
      reset = 1'b0; Start = 1'b0; Ack = 1'b0;
      Bird_X_L = 10'd100; Bird_X_R = 10'd116; Bird_Y_T = 10'd200; Bird_Y_B = 10'd216;

      // Reset values
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_idle", q_Idle, 1);
      chk("rst_score", Score, 0);
      chk("rst_coll", Collision, 0);
      chk("rst_xr0", Pipe0_XR, 700);
      chk("rst_xr1", Pipe1_XR, 1020);
      chk("rst_gap0", Pipe0_GapT, 80);
      chk("rst_gap1", Pipe1_GapT, 80);
      #2 reset = 1'b1;
      step();
      chk("idle_hold", q_Idle, 1);

      // Start: gaps drawn from the pre-advance LFSR
      Start = 1'b1; L = m_lfsr;
      step();
      Start = 1'b0;
      mxr0 = 700; mxr1 = 1020; ms = 0;
      mg0 = 80 + L[6:0]; mg1 = 80 + L[7:1];
      chk("start_run", q_Run, 1);
      chk("start_score", Score, 0);
      chk("start_gap0", Pipe0_GapT, mg0);
      chk("start_gap1", Pipe1_GapT, mg1);
      chk("start_xr0", Pipe0_XR, 700);

      // Pass: bird at X 100..116 tracking the next pipe's gap
      for (int c = 0; c < 1030; c++) begin
         g = (mxr0 > 100 && (mxr1 <= 100 || mxr0 < mxr1)) ? mg0 : mg1;
         Bird_Y_T = 10'(g + 50); Bird_Y_B = 10'(g + 66);
         L = m_lfsr;
         scored = (mxr0 == 100) || (mxr1 == 100);
         if (scored && ms < 255) ms++;
         resp = 1'b0;
         if (mxr0 == 0) begin
            mxr1--; mxr0 = mxr1 + 320; mg0 = 80 + L[6:0]; resp = 1'b1;
         end else if (mxr1 == 0) begin
            mxr0--; mxr1 = mxr0 + 320; mg1 = 80 + L[6:0]; resp = 1'b1;
         end else begin
            mxr0--; mxr1--;
         end
         step();
         if (scored) chk("pass_score", Score, ms);
         if (resp) begin
            chk("resp_xr0", Pipe0_XR, mxr0);
            chk("resp_xr1", Pipe1_XR, mxr1);
            chk("resp_gap0", Pipe0_GapT, mg0);
            chk("resp_gap1", Pipe1_GapT, mg1);
            chk("resp_gap_range", (Pipe0_GapT >= 80 && Pipe0_GapT <= 207 &&
                                   Pipe1_GapT >= 80 && Pipe1_GapT <= 207), 1);
         end
      end
      chk("pass_total", Score, 2);
      chk("pass_run", q_Run, 1);

      // Floor: hit one edge later, pipes frozen afterwards
      Bird_Y_T = 10'd463; Bird_Y_B = 10'd479;
      #1;
      chk("floor_pre", Collision, 0);
      step();
      chk("floor_hit", q_Hit, 1);
      chk("floor_coll", Collision, 1);
      chk("floor_xr0", Pipe0_XR, mxr0);
      chk("floor_xr1", Pipe1_XR, mxr1);
      repeat (50) step();
      chk("frozen_xr0", Pipe0_XR, mxr0);
      chk("frozen_xr1", Pipe1_XR, mxr1);
      chk("frozen_score", Score, 2);

      // Handshake
      Start = 1'b1;
      step();
      Start = 1'b0;
      chk("hit_ign_start", q_Hit, 1);
      Ack = 1'b1;
      step();
      Ack = 1'b0;
      chk("ack_idle", q_Idle, 1);
      chk("ack_score", Score, 2);
      chk("ack_xr0", Pipe0_XR, 700);
      chk("ack_xr1", Pipe1_XR, 1020);

      // Pipe: bird X 630..646 overlaps Pipe0 at XR=700 on the first RUN cycle
      Bird_X_L = 10'd630; Bird_X_R = 10'd646; Bird_Y_T = 10'd200; Bird_Y_B = 10'd216;
      Start = 1'b1; L = m_lfsr;
      step();
      Start = 1'b0;
      mg0 = 80 + L[6:0];
      chk("restart_score", Score, 0);
      chk("restart_run", q_Run, 1);
      Bird_Y_T = 10'(mg0 - 5); Bird_Y_B = 10'(mg0 + 11);
      step();
      chk("pipe_top_hit", q_Hit, 1);
      chk("pipe_top_xr0", Pipe0_XR, 700);

      // Bottom edge inclusive: GapT+GAP_H is clear, one more pixel hits
      Ack = 1'b1;
      step();
      Ack = 1'b0;
      Start = 1'b1; L = m_lfsr;
      step();
      Start = 1'b0;
      mg0 = 80 + L[6:0];
      Bird_Y_T = 10'(mg0 + 104); Bird_Y_B = 10'(mg0 + 120);
      repeat (2) step();
      chk("pipe_edge_run", q_Run, 1);
      chk("pipe_edge_xr0", Pipe0_XR, 698);
      Bird_Y_T = 10'(mg0 + 105); Bird_Y_B = 10'(mg0 + 121);
      step();
      chk("pipe_bot_hit", q_Hit, 1);
      chk("pipe_bot_xr0", Pipe0_XR, 698);

      // Asynchronous reset between edges mid-run
      Ack = 1'b1;
      step();
      Ack = 1'b0;
      Bird_X_L = 10'd100; Bird_X_R = 10'd116; Bird_Y_T = 10'd200; Bird_Y_B = 10'd216;
      Start = 1'b1;
      step();
      Start = 1'b0;
      repeat (3) step();
      chk("pre_arst_run", q_Run, 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_idle", q_Idle, 1);
      chk("arst_coll", Collision, 0);
      chk("arst_score", Score, 0);
      chk("arst_xr0", Pipe0_XR, 700);
      chk("arst_xr1", Pipe1_XR, 1020);
      chk("arst_gap0", Pipe0_GapT, 80);
      chk("arst_gap1", Pipe1_GapT, 80);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_collision.md
Name: pipe_collision

Overview:
- Consumer side of the bird-motion interface: takes the bird bounding box produced by flight_physics and returns the game-over event.
- Scrolls two pipes right-to-left with pseudo-random gap heights and keeps the score.
- Flags a collision with a pipe, the floor or the ceiling, then holds the game stopped until acknowledged.
- Sits between flight_physics and the VGA renderer; its Collision output feeds the top-level game controller.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
PIPE_W, 60, pipe width in pixels
GAP_H, 120, vertical gap height in pixels
GAP_MIN, 80, minimum gap top Y
PIPE_SPACING, 320, right-edge distance between the two pipes
SCROLL_DIV, 200000, clocks per 1-pixel scroll step (must be >= 1)

Ports:
Clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
Start  in  1  begin a run (sampled in IDLE only)
Ack  in  1  acknowledge game over (sampled in HIT only)
Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B  in  10 each  bird bounding box from flight_physics
Pipe0_XR, Pipe1_XR  out  10 each  pipe right edges (left edge = XR-PIPE_W, may underflow; renderer clips)
Pipe0_GapT, Pipe1_GapT  out  10 each  gap top Y; gap spans GapT..GapT+GAP_H inclusive
Score  out  8  pipes passed, saturating at 255
Collision  out  1  high while in HIT
q_Idle, q_Run, q_Hit  out  1 each  one-hot state

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; Score=0; Collision=0.
  - Pipe0_XR=SCREEN_W+PIPE_W (700); Pipe1_XR=Pipe0_XR+PIPE_SPACING (1020).
  - Both GapT=GAP_MIN; LFSR=8'hA5; scroll counter=0.
- Reset deasserted mid-run: the block restarts in IDLE, with no partial update on the releasing edge.
- Parameter constraint: SCREEN_W+PIPE_W+PIPE_SPACING <= 1023 (checked by elaboration assertion).
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1, advances every clock in every state. It never reaches zero.
- Gap draw: new GapT = GAP_MIN + lfsr[6:0], using the current (pre-advance) LFSR value.
- IDLE:
  - Pipes are held at their reset positions.
  - Score holds its last value so the final score stays displayed.
  - Start=1 -> RUN on the next edge. On that edge: Score cleared, Pipe0_GapT drawn, Pipe1_GapT = GAP_MIN + lfsr[7:1], scroll counter cleared.
- RUN:
  - The scroll counter counts 0..SCROLL_DIV-1. On wrap (a tick), both XR decrement by 1.
  - Respawn: a pipe whose XR is 0 at a tick gets XR = other_pipe_XR_after_tick + PIPE_SPACING and a freshly drawn GapT.
  - Score: on a tick where a pipe's XR equals Bird_X_L before decrement, Score increments (saturate at 255). At most one pipe can score per tick.
- Hit condition, combinational on current inputs and registered pipe state:
  - Floor: Bird_Y_B >= SCREEN_H-1.
  - Ceiling: Bird_Y_T == 0.
  - Pipe, for either pipe: horizontal overlap (Bird_X_R >= XR-PIPE_W, with the left edge clamped to 0 when XR < PIPE_W, AND Bird_X_L < XR) combined with (Bird_Y_T < GapT OR Bird_Y_B > GapT+GAP_H).
  - Use 11-bit intermediates for all sums; no wrap-around in the compares.
- RUN -> HIT on the edge where the hit condition is true: 1-cycle latency. If a tick and a hit coincide, the hit wins: pipes, Score and counter are not updated on that edge.
- HIT:
  - Collision=1; pipes, gaps and Score are frozen.
  - Ack=1 -> IDLE on the next edge. On entry to IDLE, pipes return to their reset positions.
  - Start is ignored in HIT; Ack is ignored in IDLE and RUN.
- All outputs are registered except Collision and q_*, which decode the state register directly.

Decomposition:
- Shared package flappy_pkg holds the state encoding, the screen constants SCREEN_W/SCREEN_H and the LFSR seed; these are shared with flight_physics and the renderer.
- One natural sub-module: flappy_lfsr8 (free-running 8-bit Galois LFSR with seed parameter).

Test Plan:
- Use SCROLL_DIV=1 for speed in all scenarios.
- Reset: reset=0 -> q_Idle=1, Score=0, Collision=0, Pipe0_XR=700, Pipe1_XR=1020, both GapT=80.
- Pass: Start pulse; the bench places the bird at X 100..116, Y tracking the nearest pipe's GapT+50..GapT+66. After Pipe0 crosses, Score=1; after both pipes cross, Score=2. Each respawn lands at other_XR+320 with GapT in 80..207 matching the bench LFSR model.
- Floor: in RUN, drive Bird_Y_B=479 -> q_Hit=1 and Collision=1 exactly one edge later. Pipe XR values are frozen for 50 further cycles.
- Pipe: the bird overlaps Pipe0 horizontally with Bird_Y_T=GapT-5 -> HIT one edge after the first overlapping cycle. Repeat with Bird_Y_B=GapT+GAP_H: no hit. Repeat with Bird_Y_B=GapT+GAP_H+1: hit.
- Handshake: in HIT, Start=1 -> no change; Ack=1 -> IDLE with Score held and pipes reset to 700/1020. A following Start -> Score=0, q_Run=1.
- Async reset mid-RUN: pull reset low between edges -> outputs return to reset values immediately, with no clock required.
